// File: rtl/mdu_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit_pkg
// Description : Operation encodings, default latencies and op-class helpers
//               shared by the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8,
        MDU_MSUB  = 4'd9,
        MDU_MSUBU = 4'd10
    } mdu_op_e;

    localparam int c_MULT_CYCLES_DEFAULT = 5;
    localparam int c_DIV_CYCLES_DEFAULT  = 10;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_MSUBU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_move_op(input logic [3:0] op);
        return (op == MDU_MTHI) || (op == MDU_MTLO);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV) ||
               (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// Module      : mdu_divider
// Description : Combinational signed/unsigned quotient and remainder, with
//               divide-by-zero detection and the most-negative / -1 case.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_is_signed,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_ovf;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_safe_b;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;

    assign o_div_zero = (i_divisor == '0);
    assign w_neg_a    = i_is_signed & i_dividend[WIDTH-1];
    assign w_neg_b    = i_is_signed & i_divisor[WIDTH-1];

    // Magnitudes are unsigned, so the most-negative value maps to 2^(WIDTH-1).
    assign w_mag_a  = w_neg_a ? -i_dividend : i_dividend;
    assign w_mag_b  = w_neg_b ? -i_divisor  : i_divisor;
    assign w_safe_b = o_div_zero ? c_ONE : w_mag_b;

    assign w_uq = w_mag_a / w_safe_b;
    assign w_ur = w_mag_a % w_safe_b;

    assign w_ovf = i_is_signed && (i_dividend == c_MOST_NEG) && (i_divisor == '1);

    assign o_quotient  = w_ovf ? c_MOST_NEG :
                         (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
    assign o_remainder = w_ovf ? '0 :
                         w_neg_a ? -w_ur : w_ur;

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO,
//               multiply-accumulate ops and mthi/mtlo moves.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = c_MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = c_DIV_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mduOp,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             req,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_N  = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_N   = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic                 w_issue;
    logic                 w_signed;
    logic [2*WIDTH-1:0]   w_ext_a;
    logic [2*WIDTH-1:0]   w_ext_b;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_acc;
    logic [2*WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_div_zero;

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

    assign w_issue = start && !req && !busy && is_valid_op(mduOp);

    // Sign-extending to 2*WIDTH makes one multiplier serve both signednesses.
    assign w_signed = is_signed_op(r_op);
    assign w_ext_a  = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_ext_b  = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod   = w_ext_a * w_ext_b;
    assign w_acc    = {r_hi, r_lo};

    mdu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .i_dividend  (r_a),
        .i_divisor   (r_b),
        .i_is_signed (w_signed),
        .o_quotient  (w_quot),
        .o_remainder (w_rem),
        .o_div_zero  (w_div_zero)
    );

    always_comb begin
        w_res = w_acc;
        case (r_op)
            MDU_MULT, MDU_MULTU: w_res = w_prod;
            MDU_MADD, MDU_MADDU: w_res = w_acc + w_prod;
            MDU_MSUB, MDU_MSUBU: w_res = w_acc - w_prod;
            MDU_DIV,  MDU_DIVU:  w_res = w_div_zero ? w_acc : {w_rem, w_quot};
            default:             w_res = w_acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        if (mduOp == MDU_MTHI) begin
                            r_hi <= dataA;
                        end else if (mduOp == MDU_MTLO) begin
                            r_lo <= dataA;
                        end else begin
                            r_state <= S_RUN;
                            r_cnt   <= is_div_op(mduOp) ? c_DIV_N : c_MULT_N;
                            r_op    <= mduOp;
                            r_a     <= dataA;
                            r_b     <= dataB;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == c_CNT_ONE) begin
                        {r_hi, r_lo} <= w_res;
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_unit
// Description : Self-checking bench for mdu_unit: directed vectors plus
//               random ops against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

    localparam int W  = 32;
    localparam int MN = 5;
    localparam int DN = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    mduOp;
    logic [W-1:0]  dataA;
    logic [W-1:0]  dataB;
    logic          req;
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mhi    = '0;
    logic [W-1:0] mlo    = '0;

    mdu_unit #(
        .WIDTH       (W),
        .MULT_CYCLES (MN),
        .DIV_CYCLES  (DN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mduOp (mduOp),
        .dataA (dataA),
        .dataB (dataB),
        .req   (req),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cycles_for(input logic [3:0] op);
        if (op == 4'd3 || op == 4'd4) return DN;
        if (op == 4'd1 || op == 4'd2 || (op >= 4'd7 && op <= 4'd10)) return MN;
        return 0;
    endfunction

    // Reference: plain integer arithmetic on a 64-bit {HI,LO} accumulator.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] acc;
        logic [63:0] ps;
        logic [63:0] pu;
        longint      sa;
        longint      sb;
        int          ia;
        int          ib;
        int          q;
        int          r;
        acc = {mhi, mlo};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = 64'(sa * sb);
        pu  = {32'h0, a} * {32'h0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        case (op)
            4'd1:  acc = ps;
            4'd2:  acc = pu;
            4'd7:  acc = acc + ps;
            4'd8:  acc = acc + pu;
            4'd9:  acc = acc - ps;
            4'd10: acc = acc - pu;
            4'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    acc = {32'h0, 32'h8000_0000};
                end else begin
                    q   = ia / ib;
                    r   = ia % ib;
                    acc = {32'(r), 32'(q)};
                end
            end
            4'd4: if (b != 0) acc = {a % b, a / b};
            default: ;
        endcase
        if (op == 4'd5)      mhi = a;
        else if (op == 4'd6) mlo = a;
        else                 {mhi, mlo} = acc;
    endtask

    // Entered and left just after a falling edge; the next call issues back-to-back.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rq, input string tag);
        int n;
        start = 1'b1; mduOp = op; dataA = a; dataB = b; req = rq;
        @(negedge clk);
        start = 1'b0; mduOp = 4'd0; req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            chk({tag, " hold"}, {hi, lo}, {mhi, mlo});
            n++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(n), rq ? 64'd0 : 64'(cycles_for(op)));
        if (!rq) model(op, a, b);
        chk({tag, " hi"}, 64'(hi), 64'(mhi));
        chk({tag, " lo"}, 64'(lo), 64'(mlo));
    endtask

    initial begin
        int          n;
        logic [3:0]  op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset = 1'b1; start = 1'b0; req = 1'b0; mduOp = '0; dataA = '0; dataB = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(4'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, "mult");
        chk("mult const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(4'd2, 32'hFFFF_FFFF, 32'h2, 1'b0, "multu");
        chk("multu const", {32'(hi), 32'(lo)}, 64'h0000_0001_FFFF_FFFE);
        do_op(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b0, "div");
        chk("div const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(4'd4, 32'd7, 32'd0, 1'b0, "divu_zero");
        chk("divu_zero const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        chk("div_ovf const", {32'(hi), 32'(lo)}, 64'h0000_0000_8000_0000);

        do_op(4'd5, 32'h1234_5678, 32'h0, 1'b0, "mthi");
        do_op(4'd6, 32'h9ABC_DEF0, 32'h0, 1'b0, "mtlo");
        do_op(4'd8, 32'h10, 32'h10, 1'b0, "maddu");
        chk("maddu const", {32'(hi), 32'(lo)}, 64'h1234_5678_9ABC_DFF0);

        do_op(4'd1, 32'd3, 32'd4, 1'b1, "req_block");

        // Issue during busy must be dropped, not queued.
        start = 1'b1; mduOp = 4'd1; dataA = 32'd6; dataB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            start = (n == 1); mduOp = 4'd3; dataA = 32'd100; dataB = 32'd7;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_ignore cycles", 64'(n), 64'(MN));
        model(4'd1, 32'd6, 32'd7);
        chk("busy_ignore lo", 64'(lo), 64'd42);
        chk("busy_ignore hi", 64'(hi), 64'd0);
        @(negedge clk);
        chk("busy_ignore not_queued", 64'(busy), 64'd0);

        // Reset on the third busy cycle of a divide.
        start = 1'b1; mduOp = 4'd3; dataA = 32'hFFFF_FFF9; dataB = 32'd2;
        @(negedge clk);
        start = 1'b0;
        chk("rst_run busy1", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mhi = '0; mlo = '0;
        chk("rst_run busy", 64'(busy), 64'd0);
        chk("rst_run hi", 64'(hi), 64'd0);
        chk("rst_run lo", 64'(lo), 64'd0);
        do_op(4'd1, 32'd3, 32'd4, 1'b0, "post_rst_mult");
        chk("post_rst const", {32'(hi), 32'(lo)}, 64'd12);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(1, 15));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            do_op(op, a, b, ($urandom_range(0, 9) == 0), $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
